// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcode encodings, FSM states
// and small opcode-classification helpers used by the sequencer and slice.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Opcodes that compute a + ~b + 1 and so start with the carry set.
  function automatic logic alu_is_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLTU);
  endfunction

  // Opcodes whose final carry is reported on the carry flag.
  function automatic logic alu_reports_carry(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice. B is inverted internally for SUB/SLTU so
// the sequencer only has to seed the carry with 1 to get a - b.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       cin,
  input  logic [2:0] alu_control,
  output logic       res_bit,
  output logic       cout
);

  logic b_eff;
  logic sum_bit;
  logic maj_bit;

  assign b_eff   = alu_is_sub(alu_control) ? ~b_bit : b_bit;
  assign sum_bit = a_bit ^ b_eff ^ cin;
  assign maj_bit = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);

  // Select the slice function; logic ops never produce a carry.
  always_comb begin
    res_bit = 1'b0;
    cout    = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_SUB, ALU_SLTU: begin
        res_bit = sum_bit;
        cout    = maj_bit;
      end
      ALU_AND: res_bit = a_bit & b_bit;
      ALU_XOR: res_bit = a_bit ^ b_bit;
      default: begin
        res_bit = 1'b0;
        cout    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: accepts an operand pair and opcode, runs one
// slice evaluation per clock LSB first, then presents result/zero/carry
// until the consumer takes it. One operation in flight at a time.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic               cy_q, cy_d;
  // Holds the WIDTH-1 most recent slice outputs; the last bit is merged
  // combinationally on the final RUN cycle.
  logic [WIDTH-2:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;

  logic               slice_res;
  logic               slice_cout;
  logic               shift_bit;
  logic [WIDTH-1:0]   sh_next;
  logic [WIDTH-1:0]   res_final;

  alu_serial_slice u_slice (
    .a_bit       (a_q[0]),
    .b_bit       (b_q[0]),
    .cin         (cy_q),
    .alu_control (op_q),
    .res_bit     (slice_res),
    .cout        (slice_cout)
  );

  // SLTU only needs the borrow chain; its result bits are discarded.
  function automatic logic [WIDTH-1:0] final_result(input logic [2:0]       op,
                                                    input logic [WIDTH-1:0] shifted,
                                                    input logic             last_cout);
    logic [WIDTH-1:0] r;
    if (op == ALU_SLTU) begin
      r    = '0;
      r[0] = ~last_cout;
    end else begin
      r = shifted;
    end
    return r;
  endfunction

  assign shift_bit = (op_q == ALU_SLTU) ? 1'b0 : slice_res;
  assign sh_next   = {shift_bit, sh_q};
  assign res_final = final_result(op_q, sh_next, slice_cout);

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: latch on accept, shift and carry during RUN,
  // capture the flags on the last bit.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    sh_d     = sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          op_d  = alu_control;
          idx_d = '0;
          cy_d  = alu_is_sub(alu_control);
          sh_d  = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = slice_cout;
        sh_d  = sh_next[WIDTH-1:1];
        idx_d = idx_q + CW'(1);
        if (idx_q == LAST_IDX) begin
          result_d = res_final;
          zero_d   = (res_final == '0);
          carry_d  = alu_reports_carry(op_q) ? slice_cout : 1'b0;
        end
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand, counter, carry and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq (WIDTH=8): vector table, randomised model
// vectors, DONE back-pressure and mid-RUN reset sequences.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .carry       (carry)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
  } vec_t;

  vec_t tbl[12];
  vec_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] res, input logic z, input logic c);
    vec_t v;
    v.op = op; v.a = av; v.b = bv; v.res = res; v.z = z; v.c = c;
    return v;
  endfunction

  function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    r = '0;
    c = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, av} + {1'b0, bv}; r = s[W-1:0]; c = s[W]; end
      3'b001: begin r = av - bv; c = (av >= bv); end
      3'b010: r = av & bv;
      3'b011: r = av ^ bv;
      3'b101: r = (av < bv) ? W'(1) : W'(0);
      default: r = '0;
    endcase
    return mk(op, av, bv, r, (r == '0), c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t e, input bit track, input string name);
    int n;
    @(negedge clk);
    in_valid    = 1'b1;
    a           = e.a;
    b           = e.b;
    alu_control = e.op;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    alu_control = 3'($urandom);
    if (track) sb.push_back(e);
  endtask

  task automatic collect(input string name);
    int   lat;
    bit   rdy_bad;
    vec_t e;
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(W));
    check({name, " in_ready low in RUN"}, 32'(rdy_bad), 32'd0);
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, " result"}, 32'(result), 32'(e.res));
      check({name, " zero"},   32'(zero),   32'(e.z));
      check({name, " carry"},  32'(carry),  32'(e.c));
    end
    check({name, " in_ready low in DONE"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({name, " in_ready after handshake"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    vec_t e;
    int   n;
    bit   seen;

    tbl[0]  = mk(3'b000, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
    tbl[1]  = mk(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    tbl[2]  = mk(3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
    tbl[3]  = mk(3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
    tbl[4]  = mk(3'b101, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0);
    tbl[5]  = mk(3'b101, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0);
    tbl[6]  = mk(3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    tbl[7]  = mk(3'b011, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0);
    tbl[8]  = mk(3'b111, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
    tbl[9]  = mk(3'b100, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    tbl[10] = mk(3'b110, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    tbl[11] = mk(3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    alu_control = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result",    32'(result),    32'd0);
    check("reset zero",      32'(zero),      32'd0);
    check("reset carry",     32'(carry),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i], 1'b1, $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      e = model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      start_op(e, 1'b1, $sformatf("rnd%0d", i));
      collect($sformatf("rnd%0d", i));
    end

    // Back-pressure in DONE while a new operation is offered.
    start_op(tbl[0], 1'b1, "hold");
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold latency", 32'(n), 32'(W));
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      a           = 8'h11;
      b           = 8'h22;
      alu_control = 3'b000;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result", k),    32'(result),    32'(e.res));
      check($sformatf("hold%0d zero", k),      32'(zero),      32'(e.z));
      check($sformatf("hold%0d carry", k),     32'(carry),     32'(e.c));
      check($sformatf("hold%0d in_ready", k),  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hold release out_valid", 32'(out_valid), 32'd0);
    check("hold release in_ready",  32'(in_ready),  32'd1);
    start_op(mk(3'b000, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0), 1'b1, "after_hold");
    collect("after_hold");

    // Reset during RUN discards the pending operation.
    start_op(tbl[1], 1'b0, "abort");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort in_ready",  32'(in_ready),  32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result",    32'(result),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    start_op(mk(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0), 1'b1, "post_abort");
    collect("post_abort");

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
